// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO pin-function multiplexer: register offsets,
// select nibble width and a constant-foldable ceil-log2 helper.
package gpio_pkg;

  localparam logic [3:0] OFF_SEL0    = 4'd0;
  localparam logic [3:0] OFF_SEL1    = 4'd1;
  localparam logic [3:0] OFF_SEL2    = 4'd2;
  localparam logic [3:0] OFF_SEL3    = 4'd3;
  localparam logic [3:0] OFF_IN      = 4'd4;
  localparam logic [3:0] OFF_RISE_EN = 4'd5;
  localparam logic [3:0] OFF_FALL_EN = 4'd6;
  localparam logic [3:0] OFF_STATUS  = 4'd7;
  localparam logic [3:0] OFF_LOCK    = 4'd8;

  localparam int NIB_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/gpio_pin_sync.sv
// Multi-stage pad synchroniser with single-cycle rise/fall pulses taken
// from the last stage against its own previous value.
module gpio_pin_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) stage[s] <= '0;
      prev <= '0;
    end else begin
      stage[0] <= d;
      for (int s = 1; s < STAGES; s++) stage[s] <= stage[s-1];
      prev <= stage[STAGES-1];
    end
  end

  assign q    = stage[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/gpio_portmux.sv
// Pin-function multiplexer: per-pin function select with locking, synchronised
// pin-state register and edge interrupts with write-1-to-clear status.
module gpio_portmux
  import gpio_pkg::*;
#(
  parameter int PINS        = 32,
  parameter int FUNCS       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [PINS-1:0]       pins,
  input  logic [FUNCS*PINS-1:0] func_out,
  input  logic [FUNCS*PINS-1:0] func_dir,
  output logic [PINS-1:0]       func_in,
  input  logic [31:0]           addr,
  input  logic [31:0]           sys_w_addr,
  input  logic [31:0]           sys_r_addr,
  input  logic [31:0]           sys_w_line,
  output logic [31:0]           sys_r_line,
  input  logic                  sys_w,
  input  logic                  sys_r,
  output logic                  irq
);

  localparam int SW = clog2(FUNCS);

  logic            w_hit, r_hit;
  logic [3:0]      w_off, r_off;
  logic [PINS-1:0] w_bits, w1c, set_bits;
  logic [PINS-1:0] rise_en, fall_en, status, lock;
  logic [PINS-1:0] sync_q, rise, fall;
  logic [NIB_W*32-1:0] sel_nib;
  logic [31:0]     rd_next, rd_data;
  logic            rd_valid;
  logic            unused_addr;

  assign w_hit       = sys_w && (sys_w_addr[31:4] == addr[31:4]);
  assign r_hit       = sys_r && (sys_r_addr[31:4] == addr[31:4]);
  assign w_off       = sys_w_addr[3:0];
  assign r_off       = sys_r_addr[3:0];
  assign w_bits      = sys_w_line[PINS-1:0];
  assign unused_addr = ^addr[3:0];

  // Pins beyond PINS contribute a zero nibble so SEL reads need no masking.
  for (genvar p = 0; p < 32; p++) begin : gen_pin
    if (p < PINS) begin : gen_used
      logic [SW-1:0] sel;
      logic          out, dir;

      always_ff @(posedge clk) begin
        if (rst) sel <= '0;
        else if (w_hit && w_off == 4'(p / 8) && !lock[p])
          sel <= sys_w_line[(p % 8)*NIB_W +: SW];
      end

      always_comb begin
        out = 1'b0;
        dir = 1'b0;
        for (int k = 0; k < FUNCS; k++) begin
          if (sel == SW'(k)) begin
            out = func_out[k*PINS + p];
            dir = func_dir[k*PINS + p];
          end
        end
      end

      assign pins[p]    = dir ? out : 1'bz;
      assign func_in[p] = dir ? out : pins[p];
      assign sel_nib[p*NIB_W +: NIB_W] = NIB_W'(sel);
    end else begin : gen_absent
      assign sel_nib[p*NIB_W +: NIB_W] = '0;
    end
  end

  gpio_pin_sync #(.WIDTH(PINS), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (func_in),
    .q    (sync_q),
    .rise (rise),
    .fall (fall)
  );

  assign set_bits = (rise & rise_en) | (fall & fall_en);
  assign w1c      = (w_hit && w_off == OFF_STATUS) ? w_bits : '0;

  // A hardware edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
      lock    <= '0;
    end else begin
      if (w_hit && w_off == OFF_RISE_EN) rise_en <= w_bits;
      if (w_hit && w_off == OFF_FALL_EN) fall_en <= w_bits;
      if (w_hit && w_off == OFF_LOCK)    lock    <= lock | w_bits;
      status <= (status & ~w1c) | set_bits;
    end
  end

  assign irq = |status;

  always_comb begin
    rd_next = '0;
    case (r_off)
      OFF_SEL0, OFF_SEL1, OFF_SEL2, OFF_SEL3:
        rd_next = sel_nib[{r_off[1:0], 5'b0} +: 32];
      OFF_IN:      rd_next = 32'(sync_q);
      OFF_RISE_EN: rd_next = 32'(rise_en);
      OFF_FALL_EN: rd_next = 32'(fall_en);
      OFF_STATUS:  rd_next = 32'(status);
      OFF_LOCK:    rd_next = 32'(lock);
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= r_hit;
      if (r_hit) rd_data <= rd_next;
    end
  end

  assign sys_r_line = rd_valid ? rd_data : 'z;

endmodule

// File: tb/tb_gpio_portmux.sv
// Scoreboard bench for gpio_portmux: a register-level reference model predicts
// read data, pad values and irq; a negedge monitor compares against the DUT.
module tb_gpio_portmux;

  localparam int P = 32;
  localparam int F = 4;
  localparam int S = 2;
  localparam int P2 = 12;
  localparam int F2 = 2;
  localparam logic [31:0] BASE = 32'h0000_1230;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [F*P-1:0] func_out, func_dir;
  logic [31:0]    ext_val, ext_en;
  wire  [P-1:0]   pins_w;
  logic [P-1:0]   func_in;
  logic [31:0]    sys_w_addr, sys_r_addr, sys_w_line;
  wire  [31:0]    sys_r_line;
  logic           sys_w, sys_r, irq;

  logic [F2*P2-1:0] s_out, s_dir;
  wire  [P2-1:0]    s_pins;
  logic [P2-1:0]    s_in;
  logic [31:0]      s_waddr, s_raddr, s_wline;
  wire  [31:0]      s_rline;
  logic             s_w, s_r, s_irq;

  for (genvar i = 0; i < P; i++) begin : gen_ext
    assign pins_w[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  gpio_portmux #(.PINS(P), .FUNCS(F), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .pins(pins_w), .func_out(func_out), .func_dir(func_dir),
    .func_in(func_in), .addr(BASE), .sys_w_addr(sys_w_addr), .sys_r_addr(sys_r_addr),
    .sys_w_line(sys_w_line), .sys_r_line(sys_r_line), .sys_w(sys_w), .sys_r(sys_r),
    .irq(irq)
  );

  gpio_portmux #(.PINS(P2), .FUNCS(F2), .SYNC_STAGES(S)) u_small (
    .clk(clk), .rst(rst), .pins(s_pins), .func_out(s_out), .func_dir(s_dir),
    .func_in(s_in), .addr(BASE), .sys_w_addr(s_waddr), .sys_r_addr(s_raddr),
    .sys_w_line(s_wline), .sys_r_line(s_rline), .sys_w(s_w), .sys_r(s_r),
    .irq(s_irq)
  );

  // Reference model state
  int          msel [P];
  logic [31:0] mrise, mfall, mstatus, mlock;
  logic [31:0] hist [0:S];
  logic [31:0] sb_q [$];
  int          nvec = 0;
  int          nbad = 0;

  function automatic logic [31:0] model_dir();
    logic [31:0] d;
    for (int i = 0; i < P; i++) d[i] = func_dir[msel[i]*P + i];
    return d;
  endfunction

  function automatic logic [31:0] model_pad();
    logic [31:0] d, o;
    d = model_dir();
    for (int i = 0; i < P; i++) o[i] = func_out[msel[i]*P + i];
    return (d & o) | (~d & ext_val);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nbad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Model: reads see pre-edge state, edges come from the sampled pad history.
  always @(posedge clk) begin : model
    logic [31:0] sample, q_b, p_b, setb, w1c, rv;
    int off;
    sample = model_pad();
    if (rst) begin
      for (int i = 0; i < P; i++) msel[i] = 0;
      mrise = '0; mfall = '0; mstatus = '0; mlock = '0;
      for (int k = 0; k <= S; k++) hist[k] = '0;
    end else begin
      q_b = hist[S-1];
      p_b = hist[S];
      if (sys_r && sys_r_addr[31:4] == BASE[31:4]) begin
        off = int'(sys_r_addr[3:0]);
        rv = '0;
        case (off)
          0, 1, 2, 3: for (int j = 0; j < 8; j++) rv[4*j +: 4] = 4'(msel[8*off + j]);
          4: rv = q_b;
          5: rv = mrise;
          6: rv = mfall;
          7: rv = mstatus;
          8: rv = mlock;
          default: rv = '0;
        endcase
        sb_q.push_back(rv);
      end
      setb = (q_b & ~p_b & mrise) | (~q_b & p_b & mfall);
      w1c = '0;
      if (sys_w && sys_w_addr[31:4] == BASE[31:4]) begin
        off = int'(sys_w_addr[3:0]);
        case (off)
          0, 1, 2, 3:
            for (int j = 0; j < 8; j++)
              if (!mlock[8*off + j]) msel[8*off + j] = int'((sys_w_line >> (4*j)) & (F - 1));
          5: mrise = sys_w_line;
          6: mfall = sys_w_line;
          7: w1c = sys_w_line;
          8: mlock = mlock | sys_w_line;
          default: ;
        endcase
      end
      mstatus = (mstatus & ~w1c) | setb;
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sample;
    end
  end

  // Keep the external pad drivers off any pad the DUT is driving.
  always @(posedge clk) begin
    #1;
    ext_en = ~model_dir();
  end

  always @(negedge clk) begin : monitor
    logic [31:0] exp_v;
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      checkOutput("rdata", sys_r_line, exp_v);
    end
    checkOutput("func_in", func_in, model_pad());
    checkOutput("pins", pins_w, model_pad());
    checkOutput("irq", {31'b0, irq}, {31'b0, mstatus != 0});
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic busWrite(input int off, input logic [31:0] data);
    sys_w_addr = BASE + 32'(off);
    sys_w_line = data;
    sys_w = 1'b1;
    idle(1);
    sys_w = 1'b0;
  endtask

  task automatic busRead(input int off);
    sys_r_addr = BASE + 32'(off);
    sys_r = 1'b1;
    idle(1);
    sys_r = 1'b0;
  endtask

  task automatic applyStimulus();
    int wo, ro;
    func_out = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 7) == 0) func_dir = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) ext_val = $urandom;
    rst = ($urandom_range(0, 199) == 0);
    wo = $urandom_range(0, 15);
    ro = ($urandom_range(0, 3) == 0) ? wo : int'($urandom_range(0, 15));
    sys_w = ($urandom_range(0, 2) == 0);
    sys_r = ($urandom_range(0, 2) == 0);
    sys_w_line = (wo == 8) ? ($urandom & $urandom & $urandom) : $urandom;
    sys_w_addr = (($urandom_range(0, 7) == 0) ? BASE + 32'h10 : BASE) + 32'(wo);
    sys_r_addr = (($urandom_range(0, 7) == 0) ? BASE + 32'h10 : BASE) + 32'(ro);
    ext_en = ~model_dir();
    idle(1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; sys_w = 1'b0; sys_r = 1'b0;
    sys_w_addr = BASE; sys_r_addr = BASE; sys_w_line = '0;
    func_out = '0; func_dir = '1; ext_val = '0; ext_en = '0;
    s_out = '0; s_dir = '1; s_waddr = BASE; s_raddr = BASE; s_wline = '0;
    s_w = 1'b0; s_r = 1'b0;
    idle(3);
    rst = 1'b0;

    $display("[TB] function 0 drives all pads");
    func_out[31:0] = 32'hA5A5A5A5;
    idle(2);
    checkOutput("pins_a5", pins_w, 32'hA5A5A5A5);

    $display("[TB] pin 0 to function 3 as input");
    busWrite(0, 32'h0000_0003);
    func_dir[3*P + 0] = 1'b0;
    ext_val[0] = 1'b1;
    ext_en = ~model_dir();
    #1;
    checkOutput("func_in0", {31'b0, func_in[0]}, 32'd1);
    busRead(0);
    busWrite(8, 32'h1);
    busWrite(0, 32'h0000_0002);
    busRead(0);
    busRead(8);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    busRead(0);
    busRead(8);

    $display("[TB] rise edge latency and clear");
    func_dir = '0;
    ext_val = '0;
    ext_en = ~model_dir();
    idle(4);
    busWrite(5, 32'h2);
    ext_val[1] = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (irq) break;
    end
    checkOutput("irq_latency", 32'(n), 32'd3);
    idle(1);
    busRead(7);
    busWrite(7, 32'h2);
    busRead(7);

    $display("[TB] clear racing a new edge");
    ext_val[1] = 1'b0;
    idle(4);
    ext_val[1] = 1'b1;
    idle(4);
    ext_val[1] = 1'b0;
    idle(4);
    ext_val[1] = 1'b1;
    idle(2);
    busWrite(7, 32'h2);
    checkOutput("irq_w1c_race", {31'b0, irq}, 32'd1);
    busRead(7);

    $display("[TB] 12-pin 2-function instance");
    s_waddr = BASE + 32'd1;
    s_wline = 32'hFFFF_FFFF;
    s_w = 1'b1;
    idle(1);
    s_w = 1'b0;
    s_raddr = BASE + 32'd1;
    s_r = 1'b1;
    @(posedge clk);
    #1;
    s_r = 1'b0;
    checkOutput("small_sel1", s_rline, 32'h0000_1111);
    s_raddr = BASE + 32'd12;
    s_r = 1'b1;
    @(posedge clk);
    #1;
    s_r = 1'b0;
    checkOutput("small_off12", s_rline, 32'h0);
    idle(1);

    $display("[TB] randomized traffic");
    repeat (1500) applyStimulus();
    rst = 1'b0;
    sys_w = 1'b0;
    sys_r = 1'b0;
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
